// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root controller.
// Holds the controller state encoding, datapath widths and the default
// watchdog iteration limit. StErr exists only when SQRT_CTRL_WATCHDOG_EN
// is defined.
package sqrt_pkg;

  localparam int unsigned OpWidth        = 8;   // operand a / sw
  localparam int unsigned RootWidth      = 4;   // result root
  localparam int unsigned IterCntWidth   = 5;   // watchdog iteration counter
  localparam int unsigned MaxIterDefault = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StClr  = 3'd1,
    StLoad = 3'd2,
    StTest = 3'd3,
`ifdef SQRT_CTRL_WATCHDOG_EN
    StDone = 3'd4,
    StErr  = 3'd5
`else
    StDone = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/sqrt_iter_cnt.sv
// Watchdog iteration counter for sqrt_ctrl.
// Cleared when an operand is loaded, incremented once per datapath iteration.
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset
//   clr_i   - clear counter to zero (takes priority over inc_i)
//   inc_i   - count one iteration
//   cnt_o   - current iteration count
module sqrt_iter_cnt
  import sqrt_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [IterCntWidth-1:0] cnt_o
);

  logic [IterCntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sqrt_ctrl.sv
// Control FSM for an iterative integer square-root datapath.
// The datapath starts with sq=1, del=3 and repeats sq+=del, del+=2 while
// sq <= a; the number of iterations is floor(sqrt(a)).
// Optional feature: define SQRT_CTRL_WATCHDOG_EN to add an iteration counter
// and an error state entered when MAX_ITER iterations have been made and the
// datapath still wants another.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - synchronous active-high reset
//   start  - begin a computation (sampled in IDLE only)
//   ready  - idle, start accepted
//   done   - result (or error) available, held until ack
//   ack    - requester consumed the result
//   err    - iteration limit exceeded (always 0 without the watchdog)
//   lteflg - datapath flag sq <= a
//   dp_clr - reinitialise datapath registers
//   ald, sqld, dld, outld - datapath load enables for a, sq, del, root
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int unsigned MAX_ITER = MaxIterDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready,
  output logic done,
  input  logic ack,
  output logic err,
  input  logic lteflg,
  output logic dp_clr,
  output logic ald,
  output logic sqld,
  output logic dld,
  output logic outld
);

  // The iteration counter is 5 bits wide, so larger limits could never match.
  if (MAX_ITER >= (1 << IterCntWidth)) begin : g_max_iter_range
    $error("sqrt_ctrl: MAX_ITER exceeds the iteration counter range");
  end

  state_e state_q, state_d;

`ifdef SQRT_CTRL_WATCHDOG_EN
  localparam logic [IterCntWidth-1:0] MaxIterCnt = IterCntWidth'(MAX_ITER);

  logic [IterCntWidth-1:0] iter_cnt;
  logic                    cnt_clr;

  sqrt_iter_cnt u_iter_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (cnt_clr),
    .inc_i   (sqld),
    .cnt_o   (iter_cnt)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    dp_clr  = 1'b0;
    ald     = 1'b0;
    sqld    = 1'b0;
    dld     = 1'b0;
    outld   = 1'b0;
`ifdef SQRT_CTRL_WATCHDOG_EN
    cnt_clr = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) state_d = StClr;
      end
      StClr: begin
        dp_clr  = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        ald     = 1'b1;
`ifdef SQRT_CTRL_WATCHDOG_EN
        cnt_clr = 1'b1;
`endif
        state_d = StTest;
      end
      StTest: begin
`ifdef SQRT_CTRL_WATCHDOG_EN
        // Limit reached and another iteration requested: abort without loading.
        if (lteflg && (iter_cnt == MaxIterCnt)) begin
          state_d = StErr;
        end else
`endif
        if (lteflg) begin
          sqld = 1'b1;
          dld  = 1'b1;
        end else begin
          outld   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (ack) state_d = StIdle;
      end
`ifdef SQRT_CTRL_WATCHDOG_EN
      StErr: begin
        err  = 1'b1;
        done = 1'b1;
        if (ack) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Directed self-checking bench for sqrt_ctrl. A behavioural datapath
// (a, sq, del, root) closes the loop through lteflg.
module tb_sqrt_ctrl;

`ifdef SQRT_CTRL_WATCHDOG_EN
  localparam int unsigned TbMaxIter = 4;
`else
  localparam int unsigned TbMaxIter = 16;
`endif

  logic clk = 1'b0;
  logic reset, start, ack;
  logic ready, done, err, lteflg, dp_clr, ald, sqld, dld, outld;
  logic [7:0] sw;

  // Datapath model
  logic [7:0] a;
  logic [8:0] sq;
  logic [5:0] del;
  logic [3:0] root;

  int checks = 0;
  int errors = 0;
  int sqld_total = 0;
  int outld_total = 0;
  int violations = 0;

  always #5 clk = ~clk;

  sqrt_ctrl #(.MAX_ITER(TbMaxIter)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ready  (ready),
    .done   (done),
    .ack    (ack),
    .err    (err),
    .lteflg (lteflg),
    .dp_clr (dp_clr),
    .ald    (ald),
    .sqld   (sqld),
    .dld    (dld),
    .outld  (outld)
  );

  assign lteflg = (sq <= {1'b0, a});

  always @(posedge clk) begin
    if (reset || dp_clr) begin
      a    <= 8'd0;
      sq   <= 9'd1;
      del  <= 6'd3;
      root <= 4'd0;
    end else begin
      if (ald)   a    <= sw;
      if (sqld)  sq   <= sq + {3'd0, del};
      if (dld)   del  <= del + 6'd2;
      if (outld) root <= 4'(del[5:1] - 5'd1);
    end
  end

  // Protocol monitor: counts pulses and illegal enable combinations.
  always @(posedge clk) begin
    if (sqld === 1'b1) sqld_total++;
    if (outld === 1'b1) outld_total++;
    if (sqld !== dld) violations++;
    if ((int'(dp_clr) + int'(ald) + int'(outld)) > 1) violations++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one start for val and check the finished run, then ack it.
  task automatic run_op(input logic [7:0] val, input int exp_iter, input int exp_root,
                        input int exp_cyc, input logic exp_err, input string tag);
    int cyc, s0, o0, rdy;
    bit seen;
    sw = val;
    start = 1'b1;
    s0 = sqld_total;
    o0 = outld_total;
    cyc = 0;
    rdy = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (ready) rdy++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_iters"}, sqld_total - s0, exp_iter);
    check({tag, "_outld"}, outld_total - o0, exp_err ? 0 : 1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_ready_low"}, rdy, 0);
    if (!exp_err) check({tag, "_root"}, 32'(root), exp_root);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
    check({tag, "_done_after_ack"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    sw    = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enables", {27'd0, dp_clr, ald, sqld, dld, outld}, 32'd0);

    run_op(8'd0, 0, 0, 4, 1'b0, "sw0");
    run_op(8'd16, 4, 4, 8, 1'b0, "sw16");
    run_op(8'd15, 3, 3, 7, 1'b0, "sw15");

    // ack with start held high in first done cycle; start during TEST ignored.
    sw = 8'd9;
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 4);
      if (done) seen = 1'b1;
    end
    check("hold_latency", cyc, 7);
    check("hold_root", 32'(root), 32'd3);
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("hold_idle_ready", 32'(ready), 32'd1);
    check("hold_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_reclr", 32'(dp_clr), 32'd1);
    check("hold_reclr_ready", 32'(ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("hold_rerun_done", 32'(seen), 32'd1);
    check("hold_rerun_root", 32'(root), 32'd3);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // Reset in the third TEST cycle of sw=200.
    sw = 8'd200;
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_mid_in_test", 32'(sqld), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_enables", {27'd0, dp_clr, ald, sqld, dld, outld}, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);

`ifdef SQRT_CTRL_WATCHDOG_EN
    run_op(8'd100, 4, 0, 8, 1'b1, "wd100");
`else
    run_op(8'd200, 14, 14, 18, 1'b0, "sw200");
    run_op(8'd255, 15, 15, 19, 1'b0, "sw255");
`endif

    check("protocol_violations", violations, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
